// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared definitions for the AHB-to-APB master controller.
//   state_e        - controller FSM states
//   REGn_BASE/LIM  - inclusive address window of each APB slave
//   SEL_*          - one-hot Pselx encodings (SEL_NONE = no slave selected)
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ENABLE = 2'd3
  } state_e;

  localparam logic [31:0] REG0_BASE = 32'h8000_0000;
  localparam logic [31:0] REG0_LIM  = 32'h83FF_FFFF;
  localparam logic [31:0] REG1_BASE = 32'h8400_0000;
  localparam logic [31:0] REG1_LIM  = 32'h87FF_FFFF;
  localparam logic [31:0] REG2_BASE = 32'h8800_0000;
  localparam logic [31:0] REG2_LIM  = 32'h8BFF_FFFF;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_R0   = 3'b001;
  localparam logic [2:0] SEL_R1   = 3'b010;
  localparam logic [2:0] SEL_R2   = 3'b100;

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: combinational address decode for the APB slave map.
//   addr   - AHB transfer address
//   sel    - one-hot slave select for addr (SEL_NONE when unmapped)
//   mapped - 1 when addr falls inside one of the slave windows
module apb_addr_decode
  import apb_bridge_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  sel,
  output logic        mapped
);

  always_comb begin
    sel = SEL_NONE;
    if (addr >= REG0_BASE && addr <= REG0_LIM)      sel = SEL_R0;
    else if (addr >= REG1_BASE && addr <= REG1_LIM) sel = SEL_R1;
    else if (addr >= REG2_BASE && addr <= REG2_LIM) sel = SEL_R2;
  end

  assign mapped = (sel != SEL_NONE);

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: turns single-strobe AHB requests into APB setup/enable
// transfers for a zero-wait-state slave.
//   Hclk, Hresetn          - clock, async active-low reset
//   Valid, Hwrite_in,
//   Haddr_in               - request strobe, direction and address
//   Hwdata_in              - write data, one cycle after Valid
//   Prdata                 - APB read data
//   Pwrite, Penable, Pselx,
//   Paddr, Pwdata          - APB master outputs (all registered)
//   Hreadyout, Hrdata      - ready back to AHB and captured read data
module apb_master_ctrl
  import apb_bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Valid,
  input  logic        Hwrite_in,
  input  logic [31:0] Haddr_in,
  input  logic [31:0] Hwdata_in,
  input  logic [31:0] Prdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout,
  output logic [31:0] Hrdata
);

  state_e     state;
  logic [2:0] dec_sel;
  logic       dec_mapped;
  // Select is held here during the write-data wait so Pselx only rises
  // once Pwdata is valid, i.e. at the true APB setup phase.
  logic [2:0] sel_q;

  apb_addr_decode u_dec (
    .addr   (Haddr_in),
    .sel    (dec_sel),
    .mapped (dec_mapped)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Pselx     <= SEL_NONE;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
      Hrdata    <= '0;
      sel_q     <= SEL_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          // Unmapped requests are dropped silently; ready stays high.
          if (Valid && dec_mapped) begin
            Paddr     <= Haddr_in;
            Pwrite    <= Hwrite_in;
            sel_q     <= dec_sel;
            Hreadyout <= 1'b0;
            if (Hwrite_in) begin
              state <= ST_WWAIT;
            end else begin
              Pselx <= dec_sel;
              state <= ST_SETUP;
            end
          end
        end
        ST_WWAIT: begin
          Pwdata <= Hwdata_in;
          Pselx  <= sel_q;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          Penable <= 1'b1;
          state   <= ST_ENABLE;
        end
        ST_ENABLE: begin
          Penable   <= 1'b0;
          Pselx     <= SEL_NONE;
          Hreadyout <= 1'b1;
          if (!Pwrite) Hrdata <= Prdata;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed bench for apb_master_ctrl with a
// transaction-timeline model checked every cycle plus literal checks.
module tb_apb_master_ctrl;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        Valid = 1'b0;
  logic        Hwrite_in = 1'b0;
  logic [31:0] Haddr_in = '0;
  logic [31:0] Hwdata_in = '0;
  logic [31:0] Prdata = '0;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Hrdata;

  apb_master_ctrl dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Valid(Valid), .Hwrite_in(Hwrite_in),
    .Haddr_in(Haddr_in), .Hwdata_in(Hwdata_in), .Prdata(Prdata),
    .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Slave map taken directly from the address windows.
  function automatic logic [2:0] map_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
    if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
    if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
    return 3'b000;
  endfunction

  // Model: a transaction is described by its age in cycles since Valid.
  // Reads: age1 setup, age2 enable. Writes: age1 data wait, age2 setup,
  // age3 enable. Outside a transaction the bus is idle and ready is high.
  logic        m_act = 1'b0;
  int          m_age = 0;
  logic        m_wr = 1'b0;
  logic [2:0]  m_sel = '0;
  logic        e_wr = 1'b0, e_en = 1'b0, e_rdy = 1'b1;
  logic [2:0]  e_sel = '0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

  task automatic model_outputs();
    int ph;
    ph    = m_wr ? m_age - 1 : m_age;
    e_sel = (ph >= 1) ? m_sel : 3'b000;
    e_en  = (ph == 2);
    e_rdy = 1'b0;
  endtask

  // Compare process: at each falling edge, check the DUT against the model,
  // then advance the model using the inputs the next rising edge will see.
  initial begin
    forever begin
      @(negedge Hclk);
      if (!Hresetn) begin
        m_act = 0; m_age = 0; e_wr = 0; e_en = 0; e_rdy = 1; e_sel = 0;
        e_addr = 0; e_wdata = 0; e_rdata = 0;
      end
      chk("Pselx",     {29'd0, Pselx}, {29'd0, e_sel});
      chk("Penable",   {31'd0, Penable}, {31'd0, e_en});
      chk("Hreadyout", {31'd0, Hreadyout}, {31'd0, e_rdy});
      chk("Pwrite",    {31'd0, Pwrite}, {31'd0, e_wr});
      chk("Paddr",     Paddr, e_addr);
      chk("Pwdata",    Pwdata, e_wdata);
      chk("Hrdata",    Hrdata, e_rdata);
      if (Hresetn) begin
        if (m_act) begin
          if (m_wr && m_age == 1) e_wdata = Hwdata_in;
          if (!m_wr && m_age == 2) e_rdata = Prdata;
          m_age++;
          if (m_age > (m_wr ? 3 : 2)) begin
            m_act = 0; e_sel = 0; e_en = 0; e_rdy = 1;
          end else model_outputs();
        end else if (Valid && map_sel(Haddr_in) != 3'b000) begin
          m_act = 1; m_age = 1; m_wr = Hwrite_in; m_sel = map_sel(Haddr_in);
          e_addr = Haddr_in; e_wr = Hwrite_in;
          model_outputs();
        end
      end
    end
  end

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge Hclk); #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] a);
    Valid = 1'b1; Hwrite_in = wr; Haddr_in = a;
    step();
    Valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_rdy", {31'd0, Hreadyout}, 32'd1);
    chk("rst_sel", {29'd0, Pselx}, 32'd0);
    Hresetn = 1'b1;
    step();

    // Read at region 0.
    Prdata = 32'hDEAD_BEEF;
    req(1'b0, 32'h8000_0010);                 // now in SETUP
    @(negedge Hclk);
    chk("rd_setup_sel", {29'd0, Pselx}, 32'b001);
    chk("rd_setup_en", {31'd0, Penable}, 32'd0);
    step();                                   // ENABLE
    @(negedge Hclk);
    chk("rd_enable_en", {31'd0, Penable}, 32'd1);
    step();                                   // IDLE
    @(negedge Hclk);
    chk("rd_hrdata", Hrdata, 32'hDEAD_BEEF);
    chk("rd_ready", {31'd0, Hreadyout}, 32'd1);
    chk("rd_idle_sel", {29'd0, Pselx}, 32'd0);
    Prdata = 32'h0;

    // Write at region 1; data follows Valid by one cycle.
    step();
    req(1'b1, 32'h8400_0004);                 // WWAIT
    Hwdata_in = 32'h1234_5678;
    step();                                   // SETUP
    Hwdata_in = 32'hFFFF_0000;
    @(negedge Hclk);
    chk("wr_setup_sel", {29'd0, Pselx}, 32'b010);
    chk("wr_setup_pwrite", {31'd0, Pwrite}, 32'd1);
    chk("wr_setup_pwdata", Pwdata, 32'h1234_5678);
    step();                                   // ENABLE
    @(negedge Hclk);
    chk("wr_enable_pwdata", Pwdata, 32'h1234_5678);
    chk("wr_enable_rdy", {31'd0, Hreadyout}, 32'd0);
    step();                                   // 4 cycles after Valid
    @(negedge Hclk);
    chk("wr_ready", {31'd0, Hreadyout}, 32'd1);
    chk("wr_hold_paddr", Paddr, 32'h8400_0004);
    chk("wr_hrdata_kept", Hrdata, 32'hDEAD_BEEF);

    // Unmapped addresses, including just outside the windows.
    step();
    req(1'b0, 32'h9000_0000);
    req(1'b1, 32'h8C00_0000);
    req(1'b0, 32'h7FFF_FFFF);
    @(negedge Hclk);
    chk("unmap_sel", {29'd0, Pselx}, 32'd0);
    chk("unmap_rdy", {31'd0, Hreadyout}, 32'd1);
    chk("unmap_paddr", Paddr, 32'h8400_0004);

    // Back-to-back: read at region 2 then write at region 0 on the first
    // ready cycle; a stray Valid during SETUP of the read.
    step();
    Prdata = 32'hA5A5_0001;
    req(1'b0, 32'h8BFF_FFFC);                 // SETUP
    Valid = 1'b1; Hwrite_in = 1'b1; Haddr_in = 32'h8400_0000;
    step();                                   // ENABLE, stray ignored
    Valid = 1'b0;
    @(negedge Hclk);
    chk("stray_paddr", Paddr, 32'h8BFF_FFFC);
    chk("stray_sel", {29'd0, Pselx}, 32'b100);
    step();                                   // IDLE, ready
    req(1'b1, 32'h8000_0000);                 // WWAIT
    Hwdata_in = 32'h0BAD_F00D;
    step();                                   // SETUP
    @(negedge Hclk);
    chk("b2b_rdata", Hrdata, 32'hA5A5_0001);
    chk("b2b_sel", {29'd0, Pselx}, 32'b001);
    chk("b2b_pwdata", Pwdata, 32'h0BAD_F00D);
    step(); step();

    // Reset during ENABLE of a read.
    Prdata = 32'h5555_AAAA;
    req(1'b0, 32'h8000_0100);                 // SETUP
    step();                                   // ENABLE
    Hresetn = 1'b0;
    #1;
    chk("arst_en", {31'd0, Penable}, 32'd0);
    chk("arst_sel", {29'd0, Pselx}, 32'd0);
    chk("arst_rdy", {31'd0, Hreadyout}, 32'd1);
    chk("arst_hrdata", Hrdata, 32'd0);
    step();
    Hresetn = 1'b1;
    step();

    // First request after reset behaves normally.
    Prdata = 32'hCAFE_0042;
    req(1'b0, 32'h8800_0000);
    step(); step();
    @(negedge Hclk);
    chk("post_rst_hrdata", Hrdata, 32'hCAFE_0042);
    step(); step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
